// File: rtl/sng_pkg.sv
// Shared types and helpers for the multi-channel stochastic number generator:
// random-source select, FSM states, maximal LFSR tap masks and bit reversal.
package sng_pkg;

  typedef enum logic [1:0] {
    SRC_LFSR     = 2'd0,
    SRC_REVCNT   = 2'd1,
    SRC_LFSR_ROT = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  // Mask bit i feeds stage i into the XOR; all entries give maximal-length sequences.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hB400;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[4'(i)] = v[4'(width - 1 - i)];
    end
    return r;
  endfunction

  // Reserved encoding 3 falls back to the shared LFSR.
  function automatic src_e src_decode(input logic [1:0] m);
    case (m)
      2'd1:    return SRC_REVCNT;
      2'd2:    return SRC_LFSR_ROT;
      default: return SRC_LFSR;
    endcase
  endfunction

endpackage

// File: rtl/sng_multi_if.sv
// Request/stream bundle between the SNG and its neighbours; the master side
// issues start/operands and accepts bits, the slave side is the generator.
interface sng_multi_if #(
  parameter int WIDTH = 8,
`ifdef SNG_MULTI_PACK_EN
  parameter int BSL   = 255,
`endif
  parameter int N_CH  = 4
);

  logic                    start;
  logic [1:0]              mode;
  logic [N_CH*WIDTH-1:0]   a;
  logic [N_CH-1:0]         bit_out;
  logic                    bit_vld;
  logic                    bit_rdy;
  logic                    busy;
  logic                    done;

`ifdef SNG_MULTI_PACK_EN
  logic [N_CH*BSL-1:0]     a_sbs;

  modport master (
    output start, mode, a, bit_rdy,
    input  bit_out, bit_vld, busy, done, a_sbs
  );

  modport slave (
    input  start, mode, a, bit_rdy,
    output bit_out, bit_vld, busy, done, a_sbs
  );
`else
  modport master (
    output start, mode, a, bit_rdy,
    input  bit_out, bit_vld, busy, done
  );

  modport slave (
    input  start, mode, a, bit_rdy,
    output bit_out, bit_vld, busy, done
  );
`endif

endinterface

// File: rtl/sng_lfsr.sv
// Fibonacci shift-left LFSR shared by all channels; load/step take effect next cycle,
// holds its value whenever step is low (this is how downstream stalls freeze the stream).
module sng_lfsr
  import sng_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'd244)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS    = WIDTH'(lfsr_taps(WIDTH));
  // An all-zero state would lock up the register, so substitute 1.
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] lfsr_q;
  logic             fb;

  assign fb = ^(lfsr_q & TAPS);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr_q <= SEED_NZ;
    end else if (step) begin
      lfsr_q <= {lfsr_q[WIDTH-2:0], fb};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/sng_multi.sv
// N_CH-channel stochastic number generator: start -> bits next cycle, BSL transfers, done pulse.
// bit_rdy low freezes counter, LFSR and bit_out; SNG_MULTI_PACK_EN adds the packed a_sbs buffer.
module sng_multi
  import sng_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               N_CH      = 4,
  parameter int               BSL       = 255,
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(8'd244)
) (
  input  logic        clk,
  input  logic        rst,
  sng_multi_if.slave  bus
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("sng_multi: WIDTH must be within 4..16");
  end
  if (BSL < 1 || BSL > (2 ** WIDTH) - 1) begin : g_bad_bsl
    $error("sng_multi: BSL must be within 1..2^WIDTH-1");
  end

  state_e           state_q, state_d;
  src_e             mode_q;
  logic [WIDTH-1:0] a_q [N_CH];
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_rev;
  logic [WIDTH-1:0] lfsr_val;
  logic [N_CH-1:0]  bit_raw;
  logic             run;
  logic             start_acc;
  logic             xfer;
  logic             last_xfer;

  assign run       = (state_q == ST_RUN);
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign xfer      = run && bus.bit_rdy;
  assign last_xfer = xfer && (cnt_q == WIDTH'(BSL - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_xfer) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operands and source are frozen for the whole run; cnt doubles as the bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) a_q[k] <= '0;
      mode_q <= SRC_LFSR;
      cnt_q  <= '0;
    end else if (start_acc) begin
      for (int k = 0; k < N_CH; k++) a_q[k] <= bus.a[k*WIDTH +: WIDTH];
      mode_q <= src_decode(bus.mode);
      cnt_q  <= '0;
    end else if (xfer) begin
      cnt_q  <= cnt_q + WIDTH'(1);
    end
  end

  sng_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .step  (xfer),
    .value (lfsr_val)
  );

  assign cnt_rev = WIDTH'(bit_reverse(16'(cnt_q), WIDTH));

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int ROT = k % WIDTH;
    logic [WIDTH-1:0] r_rot;
    logic             b;

    if (ROT == 0) begin : g_norot
      assign r_rot = lfsr_val;
    end else begin : g_rot
      assign r_rot = {lfsr_val[WIDTH-1-ROT:0], lfsr_val[WIDTH-1 -: ROT]};
    end

    // Counter source uses strict compare because it visits r = 0; the LFSR never does.
    always_comb begin
      b = 1'b0;
      case (mode_q)
        SRC_REVCNT:   b = (a_q[k] >  cnt_rev);
        SRC_LFSR_ROT: b = (a_q[k] >= r_rot);
        default:      b = (a_q[k] >= lfsr_val);
      endcase
    end

    assign bit_raw[k] = b;
  end

  assign bus.bit_vld = run;
  assign bus.bit_out = run ? bit_raw : '0;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);

`ifdef SNG_MULTI_PACK_EN
  localparam int SBS_AW = $clog2(N_CH * BSL);

  logic [N_CH*BSL-1:0] sbs_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sbs_q <= '0;
    end else if (xfer) begin
      for (int k = 0; k < N_CH; k++) begin
        sbs_q[SBS_AW'(k * BSL) + SBS_AW'(cnt_q)] <= bit_raw[k];
      end
    end
  end

  assign bus.a_sbs = sbs_q;
`endif

endmodule

// File: tb/tb_sng_multi.sv
// Directed bench for sng_multi (WIDTH=8, N_CH=4, BSL=255): ones counts, latency,
// stall/abort repeatability, reserved mode and start-while-busy.
module tb_sng_multi;

  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 255;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

`ifdef SNG_MULTI_PACK_EN
  sng_multi_if #(.WIDTH(W), .BSL(L), .N_CH(N)) bus ();
`else
  sng_multi_if #(.WIDTH(W), .N_CH(N)) bus ();
`endif

  sng_multi #(
    .WIDTH     (W),
    .N_CH      (N),
    .BSL       (L),
    .LFSR_SEED (8'd244)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [L-1:0] cap   [N];
  logic [L-1:0] ref_a [N];
  logic [L-1:0] ref_b [N];
  logic [N-1:0] first_bits;
  int           done_cyc;
  int           stalls;
  int           nbits;
`ifdef SNG_MULTI_PACK_EN
  logic [N*L-1:0] sbs_at_done;
  logic [N*L-1:0] sbs_exp;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit same_as(input logic [L-1:0] r [N]);
    bit eq;
    eq = 1'b1;
    for (int k = 0; k < N; k++) if (cap[k] !== r[k]) eq = 1'b0;
    return eq;
  endfunction

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after done
  // (or right after the reset edge when aborting at bit index abort_at).
  task automatic run_sng(input logic [1:0] m, input logic [31:0] av, input bit stall,
                         input bit hold_start, input int abort_at, output bit aborted);
    int cyc;
    aborted    = 1'b0;
    nbits      = 0;
    stalls     = 0;
    done_cyc   = -1;
    first_bits = '0;
    for (int k = 0; k < N; k++) cap[k] = '0;
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.a       = av;
    bus.bit_rdy = 1'b1;
    step();
    cyc = 1;
    if (!hold_start) bus.start = 1'b0;
    while (cyc < 2000) begin
      if (cyc == 3) begin
        bus.a    = $urandom;
        bus.mode = 2'(m + 2'd1);
      end
      bus.bit_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.done) begin
        done_cyc = cyc;
`ifdef SNG_MULTI_PACK_EN
        sbs_at_done = bus.a_sbs;
`endif
        break;
      end
      if (bus.bit_vld) begin
        if (abort_at == nbits) begin
          rst = 1'b1;
          step();
          rst       = 1'b0;
          bus.start = 1'b0;
          aborted   = 1'b1;
          return;
        end
        if (bus.bit_rdy) begin
          for (int k = 0; k < N; k++) cap[k][8'(nbits)] = bus.bit_out[k];
          if (nbits == 0) first_bits = bus.bit_out;
          nbits++;
        end else begin
          stalls++;
        end
      end
      step();
      cyc++;
    end
    bus.start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    int seen;

    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.mode    = 2'd0;
    bus.a       = '0;
    bus.bit_rdy = 1'b0;
    step(); step(); step();
    chk("rst_bit_vld", bus.bit_vld, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_done",    bus.done,    0);
    chk("rst_bit_out", bus.bit_out, 0);
`ifdef SNG_MULTI_PACK_EN
    chk("rst_a_sbs", bus.a_sbs == '0, 1);
`endif
    bus.start = 1'b0;
    rst       = 1'b0;
    step();

    // Mode 0: LFSR starts at 244, so only a=255 fires on the first bit.
    run_sng(2'd0, {8'd255, 8'd128, 8'd1, 8'd0}, 1'b0, 1'b0, -1, ab);
    chk("m0_ones_ch0", $countones(cap[0]), 0);
    chk("m0_ones_ch1", $countones(cap[1]), 1);
    chk("m0_ones_ch2", $countones(cap[2]), 128);
    chk("m0_ones_ch3", $countones(cap[3]), 255);
    chk("m0_done_cyc", done_cyc, 256);
    chk("m0_first_bits", first_bits, 4'b1000);
    chk("m0_done_pulse_end", bus.done, 0);
    chk("m0_idle_after", bus.busy, 0);
    for (int k = 0; k < N; k++) ref_a[k] = cap[k];

    // Mode 1: bit index 0 compares against r=0, so every nonzero operand fires.
    run_sng(2'd1, 32'h40404040, 1'b0, 1'b0, -1, ab);
    for (int k = 0; k < N; k++) chk($sformatf("m1_ones_ch%0d", k), $countones(cap[k]), 64);
    chk("m1_first_bits", first_bits, 4'b1111);
    for (int k = 0; k < N; k++) ref_b[k] = cap[k];
    run_sng(2'd1, 32'h40404040, 1'b0, 1'b0, -1, ab);
    chk("m1_rerun_same", same_as(ref_b), 1);

    // Mode 2: rotations keep the count but decorrelate the channels.
    run_sng(2'd2, 32'h64646464, 1'b0, 1'b0, -1, ab);
    for (int k = 0; k < N; k++) chk($sformatf("m2_ones_ch%0d", k), $countones(cap[k]), 100);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        chk($sformatf("m2_differ_%0d_%0d", i, j), cap[i] != cap[j], 1);

    // Random backpressure must not change the stream, only stretch it.
    run_sng(2'd0, {8'd255, 8'd128, 8'd1, 8'd0}, 1'b1, 1'b0, -1, ab);
    chk("stall_stream_same", same_as(ref_a), 1);
    chk("stall_done_cyc", done_cyc, 256 + stalls);

    // Reserved mode 3 behaves as the shared LFSR.
    run_sng(2'd3, {8'd255, 8'd128, 8'd1, 8'd0}, 1'b0, 1'b0, -1, ab);
    chk("m3_as_m0", same_as(ref_a), 1);

    // Reset mid-run at bit 37.
    run_sng(2'd0, {8'd255, 8'd128, 8'd1, 8'd0}, 1'b0, 1'b0, 37, ab);
    chk("abort_taken", ab, 1);
    chk("abort_bit_vld", bus.bit_vld, 0);
    chk("abort_busy",    bus.busy,    0);
    chk("abort_done",    bus.done,    0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done) seen++;
      step();
    end
    chk("abort_no_done", seen, 0);
    run_sng(2'd0, {8'd255, 8'd128, 8'd1, 8'd0}, 1'b0, 1'b0, -1, ab);
    chk("abort_rerun_same", same_as(ref_a), 1);
    chk("abort_rerun_done", done_cyc, 256);

    // start held high through the run is ignored until IDLE.
    run_sng(2'd1, 32'h40404040, 1'b0, 1'b1, -1, ab);
    chk("hold_done_cyc", done_cyc, 256);
    chk("hold_stream_same", same_as(ref_b), 1);
`ifdef SNG_MULTI_PACK_EN
    for (int k = 0; k < N; k++)
      for (int i = 0; i < L; i++) sbs_exp[k*L + i] = cap[k][i];
    chk("pack_a_sbs", sbs_at_done === sbs_exp, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sng_multi.md
# sng_multi

Parametrised multi-channel stochastic number generator. On a `start` request it latches N_CH unsigned binary operands and streams BSL cycles of unipolar stochastic bits per channel, with a runtime-selectable random source (shared LFSR, per-channel rotated LFSR, or bit-reversed counter) and a valid/ready handshake toward the SC arithmetic datapath. It is the front-end converter that feeds the stochastic FPU lanes and replaces the single-channel, free-running generator.

## Interface
- WIDTH, 8: operand and random-source width; legal 4..16.
- N_CH, 4: number of channels converted in parallel.
- BSL, 255: bitstream length in cycles; elaboration error if BSL > 2^WIDTH-1 or BSL < 1.
- LFSR_SEED, 8'd244: LFSR seed, zero-extended or truncated to WIDTH; a zero seed is replaced by 1.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- mode  in  2  source select, latched on accepted start: 0 shared LFSR, 1 bit-reversed counter, 2 rotated LFSR, 3 reserved (treated as 0).
- a  in  N_CH*WIDTH  operands, channel k at bits [k*WIDTH +: WIDTH], latched on accepted start.
- bit_out  out  N_CH  current stochastic bit per channel.
- bit_vld  out  1  bit_out valid.
- bit_rdy  in  1  downstream accepts bit_out.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last bit is transferred.
- a_sbs  out  N_CH*BSL  packed streams, only with SNG_MULTI_PACK_EN (see Configuration).

## Operation
- FSM: IDLE -> RUN on start; RUN -> DONE on transfer of bit index BSL-1; DONE -> IDLE unconditionally.
- On accepted start: a_q <= a, mode_q <= mode, cnt <= 0, lfsr <= seed (every run is repeatable).
- Transfer = bit_vld & bit_rdy. On transfer: cnt += 1, lfsr advances one step. No transfer: cnt and lfsr hold (stall).
- LFSR: Fibonacci, shift left, feedback = XOR of tap bits of the package tap mask for WIDTH (8: 8'hB8, 16: 16'hB400); maximal length, never zero.
- Random value r_k per channel: mode 0 r_k = lfsr; mode 2 r_k = lfsr rotated left by k mod WIDTH; mode 1 r_k = bit-reverse of cnt (WIDTH bits).
- Compare: LFSR modes bit_k = (a_k >= r_k); mode 1 bit_k = (a_k > r_k). With BSL = 2^WIDTH-1 each channel emits exactly min(a_k, BSL) ones per run.
- start while busy is ignored; start and rst together: rst wins.
- a and mode changes during RUN have no effect.

## Timing
- Reset values: bit_out 0, bit_vld 0, busy 0, done 0, a_sbs 0, state IDLE, cnt 0, lfsr seed.
- bit_vld = (state == RUN); bit_out is combinational from registered a_q, lfsr, cnt.
- start sampled in cycle t -> first bit_vld in t+1; with bit_rdy held high, bits in t+1..t+BSL, done in t+BSL+1, IDLE (new start accepted) from t+BSL+2.
- Each bit_rdy low cycle in RUN delays done by one cycle.
- rst in any state: next cycle all outputs at reset values, run discarded, no done.

## Configuration
- SNG_MULTI_PACK_EN defined: a_sbs[k*BSL + i] <= bit_k on transfer of bit index i; cleared on accepted start and rst; stable and complete when done pulses, held until next start.
- Undefined: a_sbs port and buffer removed; streaming interface only.

## Structure
- Package sng_pkg: mode enum (SRC_LFSR, SRC_REVCNT, SRC_LFSR_ROT), FSM state enum, function lfsr_taps(width) returning the maximal tap mask for 4..16, function bit_reverse.
- One sub-module: sng_lfsr (WIDTH, SEED; load, step, value), shared by all channels.

## Test plan
- WIDTH=8, BSL=255, mode 0, a = {0, 1, 128, 255}, bit_rdy=1 -> ones counts {0, 1, 128, 255}, done exactly at t+256.
- Mode 1, a_k = 64 -> 64 ones per channel; first bit index 0 (r=0) is 1; rerun gives identical stream.
- Mode 2, all channels a=100 -> each 100 ones; channel streams differ pairwise (not bit-identical).
- Random bit_rdy 50% -> bit sequence identical to no-stall run, done delayed by stall count.
- rst asserted at bit 37 -> next cycle bit_vld=0, busy=0, no done; subsequent start reproduces full stream from bit 0.
- start held high during RUN -> ignored; with SNG_MULTI_PACK_EN, a_sbs at done equals captured bit_out history.
